// File: rtl/sram_1wnr_pkg.sv
// Shared types and helpers for the sram_1wnr multi-read-port RAM.
// Optional write-first forwarding is selected in the top with SRAM_1WNR_FWD_EN.
package sram_pkg;

    typedef enum logic {SRAM_CLEAR, SRAM_READY} sram_state_t;

    // Widest data word the lane-merge helper handles.
    localparam int SRAM_MAX_W = 256;

    function automatic int sram_aw(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    function automatic logic [SRAM_MAX_W-1:0] sram_lane_merge(
        input logic [SRAM_MAX_W-1:0] old_v,
        input logic [SRAM_MAX_W-1:0] nw_v,
        input logic [SRAM_MAX_W-1:0] be,
        input int                    byte_w
    );
        logic [SRAM_MAX_W-1:0] res;
        for (int i = 0; i < SRAM_MAX_W; i++) begin
            res[i] = be[i / byte_w] ? nw_v[i] : old_v[i];
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_1wnr_if.sv
// Write/read bus of sram_1wnr; the master drives writes and read requests.
interface sram_1wnr_if
    import sram_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 8,
    parameter int NUM_R  = 2,
    parameter int BYTE_W = 8
);
    localparam int AW   = sram_aw(DEPTH);
    localparam int BE_W = WIDTH / BYTE_W;

    logic                   o_busy;
    logic                   i_w_e;
    logic [AW-1:0]          i_w_addr;
    logic [BE_W-1:0]        i_w_be;
    logic [WIDTH-1:0]       i_w_data;
    logic [NUM_R-1:0]       i_r_e;
    logic [NUM_R*AW-1:0]    i_r_addr;
    logic [NUM_R*WIDTH-1:0] o_r_data;
    logic [NUM_R-1:0]       o_r_valid;

    modport master (
        input  o_busy, o_r_data, o_r_valid,
        output i_w_e, i_w_addr, i_w_be, i_w_data, i_r_e, i_r_addr
    );

    modport slave (
        output o_busy, o_r_data, o_r_valid,
        input  i_w_e, i_w_addr, i_w_be, i_w_data, i_r_e, i_r_addr
    );

endinterface

// File: rtl/sram_1wnr_clear_seq.sv
// Post-reset clear sweep for sram_1wnr: walks every entry once, then idles in READY.
//   state      | meaning
//   SRAM_CLEAR | writing INIT_VALUE to entry cnt, user traffic ignored
//   SRAM_READY | sweep done, array open to user reads and writes
module sram_clear_seq
    import sram_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int CLEAR_ON_RESET = 1,
    parameter int AW             = sram_aw(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    output logic          o_busy,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_addr
);

    localparam sram_state_t   RST_STATE = (CLEAR_ON_RESET != 0) ? SRAM_CLEAR : SRAM_READY;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    sram_state_t   state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            SRAM_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = SRAM_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = SRAM_READY;
            end
        endcase
    end

    assign o_busy     = (state_q == SRAM_CLEAR);
    assign o_clr_we   = o_busy;
    assign o_clr_addr = cnt_q;

endmodule

// File: rtl/sram_1wnr.sv
// One-write / NUM_R-read RAM with byte-lane writes, registered reads and a post-reset clear sweep.
// Define SRAM_1WNR_FWD_EN for write-first forwarding on same-cycle address collisions.
module sram_1wnr
    import sram_pkg::*;
#(
    parameter int               WIDTH          = 32,
    parameter int               DEPTH          = 8,
    parameter int               NUM_R          = 2,
    parameter int               BYTE_W         = 8,
    parameter int               CLEAR_ON_RESET = 1,
    parameter logic [WIDTH-1:0] INIT_VALUE     = '0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    sram_1wnr_if.slave  bus
);

    localparam int            AW      = sram_aw(DEPTH);
    localparam int            BE_W    = WIDTH / BYTE_W;
    localparam logic [AW:0]   DEPTH_X = (AW + 1)'(DEPTH);

    logic                busy;
    logic                clr_we;
    logic [AW-1:0]       clr_addr;

    logic                user_we;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [WIDTH-1:0]    wr_data;
    logic [BE_W-1:0]     wr_be;
    logic [WIDTH-1:0]    wr_word;

    logic [WIDTH-1:0]    mem_q [DEPTH];

    logic [AW-1:0]       rd_addr  [NUM_R];
    logic [WIDTH-1:0]    r_data_q [NUM_R];
    logic [WIDTH-1:0]    r_data_d [NUM_R];
    logic [NUM_R-1:0]    r_valid_q, r_valid_d;

    sram_clear_seq #(
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET),
        .AW             (AW)
    ) u_clear_seq (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .o_busy     (busy),
        .o_clr_we   (clr_we),
        .o_clr_addr (clr_addr)
    );

    // The sweep owns the single write port while busy; user writes are dropped.
    always_comb begin
        user_we = !busy && bus.i_w_e && ({1'b0, bus.i_w_addr} < DEPTH_X);
        if (busy) begin
            wr_en   = clr_we;
            wr_addr = clr_addr;
            wr_data = INIT_VALUE;
            wr_be   = '1;
        end else begin
            wr_en   = user_we;
            wr_addr = bus.i_w_addr;
            wr_data = bus.i_w_data;
            wr_be   = bus.i_w_be;
        end
        wr_word = WIDTH'(sram_lane_merge(SRAM_MAX_W'(mem_q[wr_addr]),
                                         SRAM_MAX_W'(wr_data),
                                         SRAM_MAX_W'(wr_be),
                                         BYTE_W));
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_word;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_R; p++) begin
            rd_addr[p] = bus.i_r_addr[p*AW +: AW];
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_R; p++) begin
            r_valid_d[p] = 1'b0;
            r_data_d[p]  = r_data_q[p];
            if (!busy && bus.i_r_e[p]) begin
                r_valid_d[p] = 1'b1;
                if ({1'b0, rd_addr[p]} < DEPTH_X) begin
`ifdef SRAM_1WNR_FWD_EN
                    r_data_d[p] = (user_we && (wr_addr == rd_addr[p])) ? wr_word
                                                                       : mem_q[rd_addr[p]];
`else
                    r_data_d[p] = mem_q[rd_addr[p]];
`endif
                end else begin
                    r_data_d[p] = '0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data_q  <= '{default: '0};
            r_valid_q <= '0;
        end else begin
            r_data_q  <= r_data_d;
            r_valid_q <= r_valid_d;
        end
    end

    for (genvar p = 0; p < NUM_R; p++) begin : g_rd_out
        assign bus.o_r_data[p*WIDTH +: WIDTH] = r_data_q[p];
    end

    assign bus.o_r_valid = r_valid_q;
    assign bus.o_busy    = busy;

endmodule

// File: tb/tb_sram_1wnr.sv
// Self-checking bench for sram_1wnr: DUT A (DEPTH 8, 4 ports, INIT DEADBEEF), DUT B (DEPTH 6, 2 ports).
module tb_sram_1wnr;

    localparam logic [31:0] INIT_A = 32'hDEADBEEF;
`ifdef SRAM_1WNR_FWD_EN
    localparam logic [31:0] COL5  = 32'h0000_0005;
    localparam logic [31:0] COLPB = 32'hDEAD_1234;
`else
    localparam logic [31:0] COL5  = 32'h0000_0000;
    localparam logic [31:0] COLPB = 32'hDEAD_BEEF;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_1wnr_if #(.WIDTH(32), .DEPTH(8), .NUM_R(4), .BYTE_W(8)) bus_a ();
    sram_1wnr_if #(.WIDTH(32), .DEPTH(6), .NUM_R(2), .BYTE_W(8)) bus_b ();

    sram_1wnr #(.WIDTH(32), .DEPTH(8), .NUM_R(4), .BYTE_W(8),
                .CLEAR_ON_RESET(1), .INIT_VALUE(INIT_A)) dut_a (
        .i_clk (clk), .i_rst (rst), .bus (bus_a));

    sram_1wnr #(.WIDTH(32), .DEPTH(6), .NUM_R(2), .BYTE_W(8),
                .CLEAR_ON_RESET(1), .INIT_VALUE(32'h0)) dut_b (
        .i_clk (clk), .i_rst (rst), .bus (bus_b));

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    endtask

    // Reference model of DUT A: plain array plus last delivered data per port.
    logic [31:0] mdl   [8];
    logic [31:0] exp_d [4];
    logic [3:0]  exp_v;

    function automatic logic [31:0] merge_bytes(input logic [31:0] o, input logic [31:0] n,
                                                input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = n[8*k +: 8];
        return r;
    endfunction

    function automatic logic [11:0] ra4(input logic [2:0] a0, input logic [2:0] a1,
                                        input logic [2:0] a2, input logic [2:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic drive_a(input logic we, input logic [2:0] wa, input logic [3:0] be,
                           input logic [31:0] wd, input logic [3:0] re, input logic [11:0] ra);
        logic [2:0]  a;
        logic [31:0] v;
        bus_a.i_w_e    = we;
        bus_a.i_w_addr = wa;
        bus_a.i_w_be   = be;
        bus_a.i_w_data = wd;
        bus_a.i_r_e    = re;
        bus_a.i_r_addr = ra;
        for (int p = 0; p < 4; p++) begin
            if (re[p]) begin
                a = ra[3*p +: 3];
                v = mdl[a];
`ifdef SRAM_1WNR_FWD_EN
                if (we && a == wa) v = merge_bytes(v, wd, be);
`endif
                exp_v[p] = 1'b1;
                exp_d[p] = v;
            end else begin
                exp_v[p] = 1'b0;
            end
        end
        @(posedge clk); #1;
        if (we) mdl[wa] = merge_bytes(mdl[wa], wd, be);
        bus_a.i_w_e = 1'b0;
        bus_a.i_r_e = '0;
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("a_valid[%0d]", p), 32'(bus_a.o_r_valid[p]), 32'(exp_v[p]));
            chk($sformatf("a_data[%0d]", p), bus_a.o_r_data[32*p +: 32], exp_d[p]);
        end
    endtask

    task automatic drive_b(input logic we, input logic [2:0] wa, input logic [31:0] wd,
                           input logic [1:0] re, input logic [2:0] ra0, input logic [2:0] ra1);
        bus_b.i_w_e    = we;
        bus_b.i_w_addr = wa;
        bus_b.i_w_be   = 4'hF;
        bus_b.i_w_data = wd;
        bus_b.i_r_e    = re;
        bus_b.i_r_addr = {ra1, ra0};
        @(posedge clk); #1;
        bus_b.i_w_e = 1'b0;
        bus_b.i_r_e = '0;
    endtask

    // Counts cycles with o_busy high after reset release; a write may be injected mid-sweep.
    task automatic sweep_a(input int inject_at, output int na, output int nb, output logic saw_rd);
        na = 0; nb = 0; saw_rd = 1'b0;
        bus_a.i_r_e    = 4'hF;
        bus_a.i_r_addr = ra4(3'd1, 3'd2, 3'd3, 3'd4);
        for (int i = 0; i < 40 && (bus_a.o_busy || bus_b.o_busy); i++) begin
            if (i == inject_at) begin
                bus_a.i_w_e = 1'b1; bus_a.i_w_addr = 3'd1;
                bus_a.i_w_be = 4'hF; bus_a.i_w_data = 32'h0BAD_F00D;
            end else begin
                bus_a.i_w_e = 1'b0;
            end
            if (bus_a.o_busy) na++;
            if (bus_b.o_busy) nb++;
            @(posedge clk); #1;
            if (bus_a.o_r_valid != 0 || bus_a.o_r_data != 0) saw_rd = 1'b1;
        end
        bus_a.i_r_e = '0;
        bus_a.i_w_e = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [3:0]  re;
        logic [11:0] ra;
        logic [3:0]  ev;
        logic [31:0] ed [4];
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [2:0] wa, input logic [3:0] be,
                                input logic [31:0] wd, input logic [3:0] re, input logic [11:0] ra,
                                input logic [3:0] ev, input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] e3);
        vec_t v;
        v.we = we; v.wa = wa; v.be = be; v.wd = wd; v.re = re; v.ra = ra; v.ev = ev;
        v.ed[0] = e0; v.ed[1] = e1; v.ed[2] = e2; v.ed[3] = e3;
        return v;
    endfunction

    vec_t tbl [11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          na, nb;
        logic        saw_rd;
        logic [11:0] rra;

        tbl[0]  = mk(1, 3'd3, 4'hF, 32'h11223344, 4'h0, '0, 4'h0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 3'd3, 4'h5, 32'hAABBCCDD, 4'h0, '0, 4'h0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 3'd0, 4'h0, 32'h0, 4'hF, ra4(3, 3, 3, 3), 4'hF,
                     32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD);
        tbl[3]  = mk(1, 3'd2, 4'hF, 32'h0, 4'h0, '0, 4'h0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 3'd2, 4'hF, 32'h5, 4'hF, ra4(2, 2, 2, 2), 4'hF, COL5, COL5, COL5, COL5);
        tbl[5]  = mk(0, 3'd0, 4'h0, 32'h0, 4'hF, ra4(2, 2, 2, 2), 4'hF, 5, 5, 5, 5);
        tbl[6]  = mk(1, 3'd4, 4'h0, 32'h12345678, 4'h0, '0, 4'h0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 3'd0, 4'h0, 32'h0, 4'h6, ra4(0, 4, 3, 0), 4'h6,
                     0, 32'hDEADBEEF, 32'h11BB33DD, 0);
        tbl[8]  = mk(1, 3'd5, 4'h3, 32'h00001234, 4'h1, ra4(5, 0, 0, 0), 4'h1, COLPB, 0, 0, 0);
        tbl[9]  = mk(1, 3'd7, 4'hC, 32'hCAFE0000, 4'h8, ra4(0, 0, 0, 5), 4'h8,
                     0, 0, 0, 32'hDEAD1234);
        tbl[10] = mk(0, 3'd0, 4'h0, 32'h0, 4'h9, ra4(7, 0, 0, 0), 4'h9,
                     32'hCAFEBEEF, 0, 0, 32'hDEADBEEF);

        bus_a.i_w_e = 0; bus_a.i_w_addr = '0; bus_a.i_w_be = '0; bus_a.i_w_data = '0;
        bus_a.i_r_e = '0; bus_a.i_r_addr = '0;
        bus_b.i_w_e = 0; bus_b.i_w_addr = '0; bus_b.i_w_be = '0; bus_b.i_w_data = '0;
        bus_b.i_r_e = '0; bus_b.i_r_addr = '0;

        // Reset values
        #12;
        chk("rst_busy_a",  32'(bus_a.o_busy), 32'd1);
        chk("rst_valid_a", 32'(bus_a.o_r_valid), 32'd0);
        chk("rst_data_a",  32'(|bus_a.o_r_data), 32'd0);
        chk("rst_busy_b",  32'(bus_b.o_busy), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        sweep_a(-1, na, nb, saw_rd);
        chk("sweep_len_a", na, 32'd8);
        chk("sweep_len_b", nb, 32'd6);
        chk("read_during_sweep", 32'(saw_rd), 32'd0);

        for (int i = 0; i < 8; i++) mdl[i] = INIT_A;
        for (int p = 0; p < 4; p++) exp_d[p] = '0;
        drive_a(0, 0, 0, 0, 4'hF, ra4(0, 1, 2, 3));
        drive_a(0, 0, 0, 0, 4'hF, ra4(4, 5, 6, 7));
        drive_a(0, 0, 0, 0, 4'h0, '0);

        // Directed vectors
        for (int i = 0; i < 11; i++) begin
            drive_a(tbl[i].we, tbl[i].wa, tbl[i].be, tbl[i].wd, tbl[i].re, tbl[i].ra);
            chk($sformatf("tbl%0d_valid", i), 32'(bus_a.o_r_valid), 32'(tbl[i].ev));
            for (int p = 0; p < 4; p++) begin
                if (tbl[i].ev[p])
                    chk($sformatf("tbl%0d_data%0d", i, p), bus_a.o_r_data[32*p +: 32], tbl[i].ed[p]);
            end
        end

        // DEPTH=6 out-of-range handling on DUT B
        drive_b(1, 3'd5, 32'hA5A5A5A5, 2'b00, 3'd0, 3'd0);
        drive_b(1, 3'd7, 32'h12345678, 2'b01, 3'd5, 3'd0);
        chk("b_rd5", bus_b.o_r_data[31:0], 32'hA5A5A5A5);
        drive_b(1, 3'd6, 32'hFFFFFFFF, 2'b11, 3'd7, 3'd5);
        chk("b_oor_valid", 32'(bus_b.o_r_valid), 32'd3);
        chk("b_oor_data",  bus_b.o_r_data[31:0], 32'h0);
        chk("b_addr5",     bus_b.o_r_data[63:32], 32'hA5A5A5A5);
        drive_b(0, 3'd0, 32'h0, 2'b00, 3'd0, 3'd0);
        chk("b_hold_valid", 32'(bus_b.o_r_valid), 32'd0);
        chk("b_hold_data0", bus_b.o_r_data[31:0], 32'h0);
        chk("b_hold_data1", bus_b.o_r_data[63:32], 32'hA5A5A5A5);
        drive_b(0, 3'd0, 32'h0, 2'b11, 3'd5, 3'd6);
        chk("b_rd5_again", bus_b.o_r_data[31:0], 32'hA5A5A5A5);
        chk("b_rd6_zero",  bus_b.o_r_data[63:32], 32'h0);

        // Randomised traffic against the model
        for (int i = 0; i < 300; i++) begin
            logic [2:0] wa;
            wa  = 3'($urandom_range(0, 7));
            rra = 12'($urandom);
            if ($urandom_range(0, 3) == 0) rra[2:0] = wa;
            drive_a(1'($urandom), wa, 4'($urandom), $urandom, 4'($urandom), rra);
        end

        // Reset mid-operation, then again mid-sweep with an illegal write injected
        rst = 1'b1;
        #3;
        chk("async_rst_busy",  32'(bus_a.o_busy), 32'd1);
        chk("async_rst_valid", 32'(bus_a.o_r_valid), 32'd0);
        chk("async_rst_data",  32'(|bus_a.o_r_data), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_sweep_busy", 32'(bus_a.o_busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sweep_a(5, na, nb, saw_rd);
        chk("restart_len_a", na, 32'd8);
        chk("restart_read_ignored", 32'(saw_rd), 32'd0);

        for (int i = 0; i < 8; i++) mdl[i] = INIT_A;
        for (int p = 0; p < 4; p++) exp_d[p] = '0;
        drive_a(0, 0, 0, 0, 4'hF, ra4(0, 1, 2, 3));
        drive_a(0, 0, 0, 0, 4'hF, ra4(4, 5, 6, 7));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sram_1wnr.md
Name: sram_1wnr

Overview:
- Parametrised successor of the 1-write/2-read block RAM with NUM_R registered read ports and byte-enable writes.
- Clears the whole array after reset with a hardware sweep, so no init file is needed for a known state.
- Used for register files, tag arrays and predictor tables where more than two read ports or partial writes are needed.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of BYTE_W.
- DEPTH, 8, number of entries; need not be a power of two.
- NUM_R, 2, number of read ports (1..8).
- BYTE_W, 8, bits per write-enable lane; BE_W = WIDTH/BYTE_W.
- CLEAR_ON_RESET, 1, 1 = sweep INIT_VALUE into every entry after reset; 0 = no sweep, array content undefined.
- INIT_VALUE, 0, WIDTH-bit value written by the sweep.

Ports:
- i_clk  in  1  clock, all logic on posedge.
- i_rst  in  1  reset, asynchronous, active-high.
- o_busy  out  1  high while the clear sweep runs; writes and reads are ignored while high.
- i_w_e  in  1  write enable.
- i_w_addr  in  AW=$clog2(DEPTH)  write address.
- i_w_be  in  BE_W  per-lane write enable; lane k covers bits [k*BYTE_W +: BYTE_W].
- i_w_data  in  WIDTH  write data.
- i_r_e  in  NUM_R  per-port read enable.
- i_r_addr  in  NUM_R*AW  packed read addresses; port p at [p*AW +: AW].
- o_r_data  out  NUM_R*WIDTH  packed registered read data.
- o_r_valid  out  NUM_R  high the cycle after an accepted read.

Behaviour:
- Clocking and reset: single clock i_clk; i_rst is asynchronous, active-high.
- Reset values:
  - o_r_data all 0 and o_r_valid all 0.
  - o_busy = 1 if CLEAR_ON_RESET, else 0.
  - Sweep counter = 0.
  - The array itself is not reset.
- FSM states: CLEAR, READY.
  - Reset enters CLEAR (or READY if CLEAR_ON_RESET = 0).
  - In CLEAR, each cycle writes INIT_VALUE (all lanes) to entry cnt and increments cnt.
  - When cnt = DEPTH-1 is written, go to READY the next cycle. The sweep lasts exactly DEPTH cycles after reset release.
  - o_busy = (state == CLEAR), driven from the state register.
  - Reset asserted mid-sweep or mid-operation returns to CLEAR with cnt = 0 and restarts the full sweep.
- Write (READY only):
  - On posedge with i_w_e = 1 and i_w_addr < DEPTH, lanes with i_w_be[k] = 1 are updated; other lanes keep their value.
  - i_w_be = 0 is a no-op.
  - Addresses >= DEPTH are ignored.
- Read (READY only), per port p:
  - Latency is 1 cycle.
  - If i_r_e[p] = 1, o_r_data[p] is loaded from array[addr] and o_r_valid[p] = 1 next cycle.
  - If i_r_e[p] = 0, o_r_data[p] holds its last value and o_r_valid[p] = 0.
  - An address >= DEPTH returns 0 with valid = 1.
- Reads during CLEAR: o_r_valid = 0 and o_r_data holds its value.
- Write and read to the same address in the same cycle: read returns the old value (read-first), unless the forwarding option is compiled in.
- Multiple ports may read the same address in the same cycle; each receives identical data.

Optional Feature:
- Macro: SRAM_1WNR_FWD_EN.
- Defined: write-first forwarding. A read with the same address and the same cycle as an accepted write returns a per-lane merge: enabled lanes take i_w_data, disabled lanes take old array data.
- Not defined: read-first (old value) on collision, with no extra muxing.

Decomposition:
- Package sram_pkg:
  - typedef enum {SRAM_CLEAR, SRAM_READY} sram_state_t.
  - Function sram_aw(depth) returning max(1, $clog2(depth)).
  - Function byte-lane merge (old, new, be).
- Sub-module sram_clear_seq: FSM plus sweep counter. Outputs o_busy, o_clr_we, o_clr_addr. The top level muxes the clear write over the user write port.

Test Plan:
- Reset release with DEPTH = 8, CLEAR_ON_RESET = 1, INIT_VALUE = 32'hDEADBEEF -> o_busy high exactly 8 cycles; then reads of all 8 addresses return 32'hDEADBEEF with valid = 1 one cycle after i_r_e.
- Write 32'h11223344 to addr 3 with be = 4'b1111, then 32'hAABBCCDD with be = 4'b0101 -> read addr 3 returns 32'h11BB33DD.
- Same-cycle write 32'h5 / read addr 2 (old value 32'h0), NUM_R = 4 with all ports reading addr 2 -> all ports return 0; with SRAM_1WNR_FWD_EN defined all return 32'h5.
- i_rst pulse at sweep cycle 4, then a write attempt during the sweep -> sweep restarts (o_busy high 8 more cycles), write ignored, entries all INIT_VALUE.
- DEPTH = 6: write to addr 7 then read addr 7 and addr 5 -> addr 7 returns 0 with valid = 1, addr 5 unchanged; i_r_e low next cycle -> o_r_data holds and valid = 0.
